breath_led_pwm: RTL and testbench
=================================

Name: breath_led_pwm

Overview:
- Downstream consumer of the selectable-rate divided clock (`clk_out`, 150–600 Hz) in the heartbeat-light design.
- Each rising edge of that slow clock steps a breathing brightness envelope: ramp up, hold, ramp down, hold, repeat.
- The envelope is rendered as a glitch-free PWM on the LED pin, clocked by the system clock.
- Changing the divider's period select therefore changes the heartbeat rate with no change to this block.

Parameters:
- PWM_BITS, 8, width of brightness and PWM counter; MAX = 2^PWM_BITS-1.
- HOLD_TICKS, 16, step edges spent at peak and at zero; legal range 1..255.
- LED_ACTIVE_LOW, 0, 1 inverts led_out polarity (off level = 1).

Ports:
- clk  input  1  system clock (same clock that drives the divider).
- rst_n  input  1  asynchronous active-low reset.
- step_clk  input  1  divided clock from the divider; a register output in the clk domain, so no synchroniser is used.
- enable  input  1  1 = breathe; 0 = LED off and envelope restarted.
- led_out  output  1  registered PWM drive to the LED pin.
- brightness  output  PWM_BITS  current envelope value.
- phase  output  2  envelope state: 00 RISE, 01 HOLD_HI, 10 FALL, 11 HOLD_LO.

Behaviour:
- Reset (async assert, sync release via clk):
  - brightness=0, phase=RISE, hold_cnt=0, pwm_cnt=0, duty_q=0, step_d=0.
  - led_out = off level (0, or 1 if LED_ACTIVE_LOW).
- Edge detect:
  - step_d <= step_clk every clk, regardless of enable.
  - step_pulse = step_clk & ~step_d, i.e. exactly one clk-wide pulse per rising edge. A level held high yields one pulse.
  - A pulse is acted on only if enable=1 in the same cycle.
- FSM (transitions occur only on an accepted step_pulse):
  - RISE: if brightness==MAX-1, then brightness<=MAX, hold_cnt<=0, go to HOLD_HI. Otherwise brightness+1.
  - HOLD_HI: if hold_cnt==HOLD_TICKS-1, then hold_cnt<=0, go to FALL. Otherwise hold_cnt+1.
  - FALL: if brightness==1, then brightness<=0, hold_cnt<=0, go to HOLD_LO. Otherwise brightness-1.
  - HOLD_LO: same as HOLD_HI, but exits to RISE.
  - Full cycle = 2*MAX + 2*HOLD_TICKS accepted pulses (542 with defaults). Brightness never wraps past 0 or MAX.
- enable=0 (synchronous, takes priority over step_pulse):
  - Next clk: brightness=0, phase=RISE, hold_cnt=0, duty_q=0.
  - pwm_cnt keeps running.
  - led_out = off level from the second clk after enable falls.
  - On re-enable, the envelope restarts from 0 in RISE.
- PWM:
  - pwm_cnt increments every clk and wraps MAX->0.
  - duty_q <= brightness when pwm_cnt==MAX, so the duty for each frame is frozen at the frame boundary; a mid-frame brightness change is never seen within the current frame.
  - led_on <= (pwm_cnt < duty_q) & enable.
  - led_out = led_on XOR LED_ACTIVE_LOW, registered, 1-clk latency from the compare.
  - Duty edge cases: duty_q=0 gives constant off; duty_q=MAX gives on for MAX of every MAX+1 clks.
- Simultaneous events:
  - A pulse in the cycle enable rises is accepted.
  - A pulse in the cycle enable falls is discarded.
  - A pulse coinciding with a frame boundary: duty_q captures the pre-update brightness.
- Reset mid-operation: all state returns to reset values immediately; no partial frame is completed.

Test Plan (PWM_BITS=4, HOLD_TICKS=2 unless noted; a step edge means step_clk 0->1 held ≥3 clk):
- Assert rst_n=0 mid-ramp at brightness 7 -> same cycle: brightness=0, phase=00, led_out=0. Repeat with LED_ACTIVE_LOW=1 -> led_out=1 and stays 1 after release while brightness=0.
- enable=1, apply 15 edges -> brightness=15, phase=01. 2 more -> phase=10. 15 more -> brightness=0, phase=11. 2 more -> phase=00. Total 34 edges; brightness never outside 0..15.
- Hold step_clk=1 for 200 clk after one rising edge -> brightness increments by exactly 1.
- Drive to brightness=5 -> led_out high exactly 5 of every 16 clk. Step to 6 at pwm_cnt=3 -> current frame still 5 high, next frame 6 high.
- Drive to FALL at brightness=9, drop enable -> next clk brightness=0, phase=00, led_out=0 by second clk. 10 edges with enable=0 -> no change. Re-enable plus 1 edge -> brightness=1.
- Defaults (PWM_BITS=8, HOLD_TICKS=16): 542 edges -> returns to phase=00, brightness=0. Peak frame shows led_out high 255 of 256 clk.

Source files
------------

// File: rtl/breath_led_pwm.sv
// rtl/breath_led_pwm.sv - breathing brightness envelope stepped by a slow clock, rendered as registered PWM
module breath_led_pwm #(
  parameter int PWM_BITS       = 8,
  parameter int HOLD_TICKS     = 16,
  parameter int LED_ACTIVE_LOW = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                step_clk,
  input  logic                enable,
  output logic                led_out,
  output logic [PWM_BITS-1:0] brightness,
  output logic [1:0]          phase
);

  localparam logic [PWM_BITS-1:0] MAX       = '1;
  localparam logic [PWM_BITS-1:0] MAX_M1    = {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam logic [PWM_BITS-1:0] ONE       = PWM_BITS'(1);
  localparam logic [7:0]          HOLD_LAST = 8'(HOLD_TICKS - 1);
  localparam logic                LED_OFF   = (LED_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    RISE    = 2'b00,
    HOLD_HI = 2'b01,
    FALL    = 2'b10,
    HOLD_LO = 2'b11
  } phase_t;

  phase_t              phase_q, phase_d;
  logic [PWM_BITS-1:0] bright_q, bright_d;
  logic [7:0]          hold_q, hold_d;
  logic                step_d;
  logic                step_pulse;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_q;
  logic                led_q;

  // step_clk is already a register in this clock domain, so one delay stage is enough for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_d <= 1'b0;
    else        step_d <= step_clk;
  end

  assign step_pulse = step_clk & ~step_d;

  // envelope state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= RISE;
      bright_q <= '0;
      hold_q   <= '0;
    end else begin
      phase_q  <= phase_d;
      bright_q <= bright_d;
      hold_q   <= hold_d;
    end
  end

  // envelope next state: disable wins over a coincident pulse; otherwise each pulse advances one step
  always_comb begin
    phase_d  = phase_q;
    bright_d = bright_q;
    hold_d   = hold_q;
    if (!enable) begin
      phase_d  = RISE;
      bright_d = '0;
      hold_d   = '0;
    end else if (step_pulse) begin
      case (phase_q)
        RISE: begin
          if (bright_q == MAX_M1) begin
            bright_d = MAX;
            hold_d   = '0;
            phase_d  = HOLD_HI;
          end else begin
            bright_d = bright_q + ONE;
          end
        end
        HOLD_HI: begin
          if (hold_q == HOLD_LAST) begin
            hold_d  = '0;
            phase_d = FALL;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
        FALL: begin
          if (bright_q == ONE) begin
            bright_d = '0;
            hold_d   = '0;
            phase_d  = HOLD_LO;
          end else begin
            bright_d = bright_q - ONE;
          end
        end
        HOLD_LO: begin
          if (hold_q == HOLD_LAST) begin
            hold_d  = '0;
            phase_d = RISE;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
        default: phase_d = RISE;
      endcase
    end
  end

  // free-running PWM frame; duty is latched only at the frame boundary so a frame never changes mid-way
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      duty_q  <= '0;
      led_q   <= LED_OFF;
    end else begin
      pwm_cnt <= pwm_cnt + ONE;
      if (!enable)              duty_q <= '0;
      else if (pwm_cnt == MAX)  duty_q <= bright_q;
      led_q <= ((pwm_cnt < duty_q) & enable) ^ LED_OFF;
    end
  end

  assign led_out    = led_q;
  assign brightness = bright_q;
  assign phase      = phase_q;

endmodule

// File: tb/tb_breath_led_pwm.sv
// tb/tb_breath_led_pwm.sv - scoreboard bench for breath_led_pwm
module tb_breath_led_pwm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       step_clk = 1'b0;
  logic       enable = 1'b0;
  logic       step_def = 1'b0;
  logic       en_def = 1'b0;
  logic       led_s, led_al, led_d;
  logic [3:0] br_s, br_al;
  logic [7:0] br_d;
  logic [1:0] ph_s, ph_al, ph_d;
  logic [3:0] tb_cnt;

  int checks = 0;
  int errors = 0;
  int n_s = 0;
  int n_d = 0;
  int hs;

  typedef struct packed {
    logic [1:0] ph;
    logic [7:0] br;
  } env_t;

  env_t exp_s[$];
  env_t exp_d[$];
  int   exp_frames[$];

  always #5 clk = ~clk;

  breath_led_pwm #(.PWM_BITS(4), .HOLD_TICKS(2), .LED_ACTIVE_LOW(0)) dut (
    .clk(clk), .rst_n(rst_n), .step_clk(step_clk), .enable(enable),
    .led_out(led_s), .brightness(br_s), .phase(ph_s)
  );

  breath_led_pwm #(.PWM_BITS(4), .HOLD_TICKS(2), .LED_ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst_n(rst_n), .step_clk(step_clk), .enable(enable),
    .led_out(led_al), .brightness(br_al), .phase(ph_al)
  );

  breath_led_pwm #(.PWM_BITS(8), .HOLD_TICKS(16), .LED_ACTIVE_LOW(0)) dut_def (
    .clk(clk), .rst_n(rst_n), .step_clk(step_def), .enable(en_def),
    .led_out(led_d), .brightness(br_d), .phase(ph_d)
  );

  // reference position inside the 16-clk PWM frame of the small instances
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cnt <= 4'd0;
    else        tb_cnt <= tb_cnt + 4'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // envelope after n accepted pulses since restart, derived from position in the cycle
  function automatic env_t env(int n, int mx, int h);
    env_t e;
    int p;
    p = n % (2 * mx + 2 * h);
    if (p < mx)               begin e.ph = 2'd0; e.br = 8'(p); end
    else if (p < mx + h)      begin e.ph = 2'd1; e.br = 8'(mx); end
    else if (p < 2 * mx + h)  begin e.ph = 2'd2; e.br = 8'(mx - (p - mx - h)); end
    else                      begin e.ph = 2'd3; e.br = 8'd0; end
    return e;
  endfunction

  task automatic pop_s(input string tag);
    env_t e;
    check({tag, "_sb"}, exp_s.size() != 0, 1);
    if (exp_s.size() != 0) begin
      e = exp_s.pop_front();
      check({tag, "_br"}, br_s, e.br);
      check({tag, "_ph"}, ph_s, e.ph);
    end
  endtask

  task automatic pop_d(input string tag);
    env_t e;
    check({tag, "_sb"}, exp_d.size() != 0, 1);
    if (exp_d.size() != 0) begin
      e = exp_d.pop_front();
      check({tag, "_br"}, br_d, e.br);
      check({tag, "_ph"}, ph_d, e.ph);
    end
  endtask

  task automatic edge_s(input int hold_clks);
    @(negedge clk);
    step_clk = 1'b1;
    if (enable) n_s++;
    exp_s.push_back(env(n_s, 15, 2));
    repeat (hold_clks) @(negedge clk);
    step_clk = 1'b0;
    repeat (2) @(negedge clk);
    pop_s("edge_s");
  endtask

  task automatic edge_d();
    @(negedge clk);
    step_def = 1'b1;
    n_d++;
    exp_d.push_back(env(n_d, 255, 16));
    repeat (3) @(negedge clk);
    step_def = 1'b0;
    repeat (2) @(negedge clk);
    pop_d("edge_d");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got 0 exp 1");
    $fatal(1, "timeout");
  end

  initial begin
    // reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_br", br_s, 0);
    check("rst_ph", ph_s, 0);
    check("rst_led", led_s, 0);
    check("rst_led_al", led_al, 1);
    check("rst_br_def", br_d, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_led", led_s, 0);
    check("idle_led_al", led_al, 1);

    // ramp to 7 then reset asynchronously mid-ramp
    enable = 1'b1;
    repeat (7) edge_s(3);
    check("ramp7", br_s, 7);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_s = 0;
    check("arst_br", br_s, 0);
    check("arst_ph", ph_s, 0);
    check("arst_led", led_s, 0);
    check("arst_led_al", led_al, 1);
    check("arst_br_al", br_al, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      repeat (5) @(negedge clk);
      check("post_rst_led_al", led_al, 1);
      check("post_rst_br_al", br_al, 0);
    end

    // one full envelope cycle
    for (int i = 0; i < 34; i++) edge_s(3);
    check("cycle_ph", ph_s, 0);
    check("cycle_br", br_s, 0);

    // a level held high counts once
    edge_s(200);
    check("held_br", br_s, 1);

    // duty 5, then a step to 6 in the middle of a frame
    repeat (4) edge_s(3);
    repeat (40) @(negedge clk);
    while (tb_cnt != 4'd0) @(negedge clk);
    exp_frames.push_back(5);
    exp_frames.push_back(5);
    exp_frames.push_back(6);
    for (int f = 0; f < 3; f++) begin
      hs = 0;
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        if (led_s) hs++;
        if (f == 1 && tb_cnt == 4'd3) begin
          step_clk = 1'b1;
          n_s++;
          exp_s.push_back(env(n_s, 15, 2));
        end
        if (f == 1 && tb_cnt == 4'd7) step_clk = 1'b0;
      end
      check("frame_high", hs, exp_frames.pop_front());
    end
    pop_s("mid_frame");

    // reach FALL at 9, then drop enable
    repeat (17) edge_s(3);
    check("fall9_br", br_s, 9);
    check("fall9_ph", ph_s, 2);
    @(negedge clk) enable = 1'b0;
    n_s = 0;
    @(negedge clk);
    check("dis_br", br_s, 0);
    check("dis_ph", ph_s, 0);
    @(negedge clk);
    check("dis_led", led_s, 0);
    hs = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (led_s) hs++;
    end
    check("dis_frame", hs, 0);
    repeat (10) edge_s(3);

    // re-enable in the same cycle as a pulse
    @(negedge clk);
    enable = 1'b1;
    step_clk = 1'b1;
    n_s++;
    exp_s.push_back(env(n_s, 15, 2));
    repeat (3) @(negedge clk);
    step_clk = 1'b0;
    repeat (2) @(negedge clk);
    pop_s("reen");
    check("reen_br", br_s, 1);

    // default parameters: peak frame and full cycle
    en_def = 1'b1;
    repeat (255) edge_d();
    check("def_peak_br", br_d, 255);
    check("def_peak_ph", ph_d, 1);
    repeat (600) @(negedge clk);
    hs = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (led_d) hs++;
    end
    check("def_peak_frame", hs, 255);
    repeat (287) edge_d();
    check("def_cycle_ph", ph_d, 0);
    check("def_cycle_br", br_d, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
